// File: rtl/sgd_drain_pkg.sv
// Shared constants and types for the updated-model FIFO drain into the host DMA path.
package sgd_drain_pkg;

    localparam int unsigned ENGINE_NUM       = 8;
    localparam int unsigned WORDS_PER_ENGINE = 4;
    localparam int unsigned BANK_FEATURES    = 64;
    localparam int unsigned DATA_WIDTH       = 512;

    // One host row covers every engine's feature bank.
    localparam int unsigned ROW_FEATURES     = ENGINE_NUM * BANK_FEATURES;
    localparam int unsigned ROW_SHIFT        = $clog2(ROW_FEATURES);
    localparam int unsigned WORD_BYTES_SHIFT = 6;

    localparam int unsigned ENG_W = $clog2(ENGINE_NUM);
    localparam int unsigned SUB_W = $clog2(WORDS_PER_ENGINE);

    typedef enum logic [5:0] {
        StIdle = 6'b000001,
        StCalc = 6'b000010,
        StCmd  = 6'b000100,
        StData = 6'b001000,
        StNext = 6'b010000,
        StDone = 6'b100000
    } state_e;

endpackage

// File: rtl/sgd_x_fifo_drain_to_dma_if.sv
// FIFO-side and DMA-side signals of the drain block, bundled with directional modports.
interface sgd_x_fifo_drain_to_dma_if;
    import sgd_drain_pkg::*;

    logic [ENGINE_NUM-1:0][DATA_WIDTH-1:0] x_to_mem_rd_data;
    logic [ENGINE_NUM-1:0]                 x_to_mem_rd_en;
    logic [ENGINE_NUM-1:0]                 x_to_mem_empty;
    logic                                  x_data_send_back_start;
    logic [63:0]                           x_data_send_back_addr;
    logic [31:0]                           x_data_send_back_length;
    logic [DATA_WIDTH-1:0]                 x_data_out;
    logic                                  x_data_out_valid;
    logic                                  x_data_out_almost_full;

    modport master (
        input  x_to_mem_rd_data,
        input  x_to_mem_empty,
        input  x_data_out_almost_full,
        output x_to_mem_rd_en,
        output x_data_send_back_start,
        output x_data_send_back_addr,
        output x_data_send_back_length,
        output x_data_out,
        output x_data_out_valid
    );

    modport slave (
        output x_to_mem_rd_data,
        output x_to_mem_empty,
        output x_data_out_almost_full,
        input  x_to_mem_rd_en,
        input  x_data_send_back_start,
        input  x_data_send_back_addr,
        input  x_data_send_back_length,
        input  x_data_out,
        input  x_data_out_valid
    );

endinterface

// File: rtl/sgd_drain_len_calc.sv
// Per-epoch transfer size: rows rounded up, then 512-bit words and bytes. Loaded on calc_i.
module sgd_drain_len_calc
    import sgd_drain_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calc_i,
    input  logic [31:0] dimension_i,
    output logic [31:0] words_o,
    output logic [31:0] length_o
);

    logic [31:0] rows;
    logic [31:0] words_d, words_q;
    logic [31:0] length_d, length_q;

    // Combinational size math; 32-bit wraparound is accepted.
    always_comb begin
        rows     = (dimension_i + 32'(ROW_FEATURES - 1)) >> ROW_SHIFT;
        words_d  = rows * 32'(ENGINE_NUM * WORDS_PER_ENGINE);
        length_d = words_d << WORD_BYTES_SHIFT;
    end

    // Capture the sizes once per run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q  <= '0;
            length_q <= '0;
        end else if (calc_i) begin
            words_q  <= words_d;
            length_q <= length_d;
        end
    end

    assign words_o  = words_q;
    assign length_o = length_q;

endmodule

// File: rtl/sgd_x_fifo_drain_to_dma.sv
// Drains the per-engine model FIFOs in host order (row, engine, word) and issues one DMA write
// per epoch. Optional stall counters are built when SGD_X_DRAIN_PERF_CNT_EN is defined.
module sgd_x_fifo_drain_to_dma
    import sgd_drain_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     started_i,
    input  logic [63:0]              addr_model_i,
    input  logic [31:0]              dimension_i,
    input  logic [31:0]              num_epochs_i,
    sgd_x_fifo_drain_to_dma_if.master bus,
    output logic                     epoch_done_o,
`ifdef SGD_X_DRAIN_PERF_CNT_EN
    output logic [31:0]              stall_full_cnt_o,
    output logic [31:0]              stall_empty_cnt_o,
`endif
    output logic                     um_done_o
);

    state_e            state_q, state_d;
    logic              started_q;
    logic [31:0]       epoch_q, epoch_d;
    logic [63:0]       base_q, base_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [ENG_W-1:0]  eng_q, eng_d;
    logic [31:0]       wcnt_q, wcnt_d;
    logic              pop_q;
    logic [ENG_W-1:0]  pop_eng_q;
    logic [31:0]       words, length;
    logic              pop, last_pop, abort;
    logic [ENGINE_NUM-1:0] rd_en;
    logic              start, valid;

    sgd_drain_len_calc u_len_calc (
        .clk         (clk),
        .rst_n       (rst_n),
        .calc_i      (state_q == StCalc),
        .dimension_i (dimension_i),
        .words_o     (words),
        .length_o    (length)
    );

    // Stall conditions and abort detection.
    always_comb begin
        abort    = !started_i && (state_q != StIdle) && (state_q != StDone);
        pop      = (state_q == StData) && started_i && !bus.x_to_mem_empty[eng_q] &&
                   !bus.x_data_out_almost_full;
        last_pop = pop && (wcnt_q == words - 32'd1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (started_i && !started_q) state_d = StCalc;
                StCalc: state_d = (num_epochs_i == 32'd0) ? StDone : StCmd;
                StCmd:  state_d = (length == 32'd0) ? StNext : StData;
                StData: if (last_pop) state_d = StNext;
                StNext: state_d = (epoch_q + 32'd1 == num_epochs_i) ? StDone : StCmd;
                StDone: if (!started_i) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Counter and address next-state.
    always_comb begin
        epoch_d = epoch_q;
        base_d  = base_q;
        sub_d   = sub_q;
        eng_d   = eng_q;
        wcnt_d  = wcnt_q;
        if (state_q == StCalc) begin
            epoch_d = '0;
            base_d  = addr_model_i;
        end else if (state_q == StCmd) begin
            sub_d  = '0;
            eng_d  = '0;
            wcnt_d = '0;
        end else if (state_q == StData && pop) begin
            wcnt_d = wcnt_q + 32'd1;
            if (sub_q == SUB_W'(WORDS_PER_ENGINE - 1)) begin
                sub_d = '0;
                eng_d = (eng_q == ENG_W'(ENGINE_NUM - 1)) ? '0 : eng_q + 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end else if (state_q == StNext) begin
            epoch_d = epoch_q + 32'd1;
            base_d  = base_q + 64'(length);
        end
    end

    // Datapath registers; pop_q/pop_eng_q track the word arriving from the FIFO next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            epoch_q   <= '0;
            base_q    <= '0;
            sub_q     <= '0;
            eng_q     <= '0;
            wcnt_q    <= '0;
            pop_q     <= 1'b0;
            pop_eng_q <= '0;
        end else begin
            started_q <= started_i;
            epoch_q   <= epoch_d;
            base_q    <= base_d;
            sub_q     <= sub_d;
            eng_q     <= eng_d;
            wcnt_q    <= wcnt_d;
            pop_q     <= pop;
            pop_eng_q <= eng_q;
        end
    end

    // Outputs; a word in flight when started drops is dropped by gating valid.
    always_comb begin
        rd_en = '0;
        if (pop) rd_en[eng_q] = 1'b1;
        start        = (state_q == StCmd) && (length != 32'd0);
        valid        = pop_q && started_i;
        epoch_done_o = (state_q == StNext);
        um_done_o    = (state_q == StDone);
    end

    assign bus.x_to_mem_rd_en          = rd_en;
    assign bus.x_data_send_back_start  = start;
    assign bus.x_data_send_back_addr   = start ? base_q : '0;
    assign bus.x_data_send_back_length = start ? length : '0;
    assign bus.x_data_out_valid        = valid;
    assign bus.x_data_out              = valid ? bus.x_to_mem_rd_data[pop_eng_q] : '0;

`ifdef SGD_X_DRAIN_PERF_CNT_EN
    logic [31:0] stall_full_q, stall_empty_q;

    // Stall counters, cleared when a new run is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_full_q  <= '0;
            stall_empty_q <= '0;
        end else if (state_q == StIdle && state_d == StCalc) begin
            stall_full_q  <= '0;
            stall_empty_q <= '0;
        end else if (state_q == StData) begin
            if (bus.x_data_out_almost_full) begin
                stall_full_q <= stall_full_q + 32'd1;
            end else if (bus.x_to_mem_empty[eng_q]) begin
                stall_empty_q <= stall_empty_q + 32'd1;
            end
        end
    end

    assign stall_full_cnt_o  = stall_full_q;
    assign stall_empty_cnt_o = stall_empty_q;
`else
    // Default build carries no stall counters.
`endif

endmodule

// File: tb/tb_sgd_x_fifo_drain_to_dma.sv
// Bench for sgd_x_fifo_drain_to_dma: FIFO models, command/word scoreboards, vector table.
module tb_sgd_x_fifo_drain_to_dma;
    import sgd_drain_pkg::*;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef struct packed { logic [63:0] addr; logic [31:0] len; } cmd_t;
    typedef struct {
        logic [31:0] dim;
        logic [31:0] epochs;
        logic [63:0] addr;
        logic [31:0] exp_len;
        bit          af_rand;
    } vec_t;

    localparam int unsigned ROW_BYTES = ENGINE_NUM * WORDS_PER_ENGINE * 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        started;
    logic [63:0] addr_model;
    logic [31:0] dimension;
    logic [31:0] num_epochs;
    logic        epoch_done;
    logic        um_done;
`ifdef SGD_X_DRAIN_PERF_CNT_EN
    logic [31:0] stall_full_cnt, stall_empty_cnt;
`endif

    sgd_x_fifo_drain_to_dma_if bus ();

    sgd_x_fifo_drain_to_dma dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .started_i    (started),
        .addr_model_i (addr_model),
        .dimension_i  (dimension),
        .num_epochs_i (num_epochs),
        .bus          (bus.master),
        .epoch_done_o (epoch_done),
`ifdef SGD_X_DRAIN_PERF_CNT_EN
        .stall_full_cnt_o  (stall_full_cnt),
        .stall_empty_cnt_o (stall_empty_cnt),
`endif
        .um_done_o    (um_done)
    );

    always #5 clk = ~clk;

    int    n_checks;
    int    n_fail;
    word_t fq[ENGINE_NUM][$];
    word_t exp_q[$];
    cmd_t  cmd_q[$];
    int    words_seen, cmds_seen, epochs_seen;
    bit    quiet;
    logic [ENGINE_NUM-1:0] force_empty;
    int    run_id;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic word_t mk_word(input int run, input int ep, input int row, input int eng,
                                      input int sub);
        logic [31:0] tag;
        tag = {8'(run), 8'(ep), 8'(row), 4'(eng), 4'(sub)};
        return {16{tag}};
    endfunction

    // Standard-FIFO model: data appears the cycle after rd_en.
    task automatic fifo_loop();
        logic [ENGINE_NUM-1:0] en;
        forever begin
            @(negedge clk);
            en = bus.x_to_mem_rd_en;
            @(posedge clk);
            #1;
            for (int e = 0; e < ENGINE_NUM; e++) begin
                if (en[e] && fq[e].size() != 0) bus.x_to_mem_rd_data[e] = fq[e].pop_front();
                bus.x_to_mem_empty[e] = (fq[e].size() == 0) || force_empty[e];
            end
        end
    endtask

    // Output monitor and scoreboard consumer.
    task automatic mon_loop();
        cmd_t  c;
        word_t w;
        forever begin
            @(negedge clk);
            if (bus.x_data_send_back_start) begin
                cmds_seen++;
                check("cmd expected", word_t'(cmd_q.size() != 0), word_t'(1));
                if (cmd_q.size() != 0) begin
                    c = cmd_q.pop_front();
                    check("cmd addr/len", word_t'({bus.x_data_send_back_addr,
                                                  bus.x_data_send_back_length}), word_t'(c));
                end
            end
            if (bus.x_data_out_valid) begin
                words_seen++;
                check("word expected", word_t'(exp_q.size() != 0), word_t'(1));
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("data word", bus.x_data_out, w);
                end
            end
            if (epoch_done) epochs_seen++;
            if (bus.x_to_mem_rd_en != '0)
                check("rd_en one-hot, non-empty",
                      word_t'($onehot(bus.x_to_mem_rd_en) &&
                              ((bus.x_to_mem_rd_en & bus.x_to_mem_empty) == '0)), word_t'(1));
            if (bus.x_data_out_almost_full)
                check("rd_en under almost_full", word_t'(bus.x_to_mem_rd_en), word_t'(0));
            if (quiet) begin
                check("rd_en after abort", word_t'(bus.x_to_mem_rd_en), word_t'(0));
                check("valid after abort", word_t'(bus.x_data_out_valid), word_t'(0));
            end
        end
    endtask

    task automatic start_run(input vec_t v);
        int rows;
        for (int e = 0; e < ENGINE_NUM; e++) fq[e].delete();
        exp_q.delete();
        cmd_q.delete();
        words_seen  = 0;
        cmds_seen   = 0;
        epochs_seen = 0;
        run_id++;
        rows = int'(v.exp_len / ROW_BYTES);
        for (int ep = 0; ep < int'(v.epochs); ep++) begin
            if (v.exp_len != 0) cmd_q.push_back({v.addr + 64'(ep) * 64'(v.exp_len), v.exp_len});
            for (int r = 0; r < rows; r++)
                for (int e = 0; e < ENGINE_NUM; e++)
                    for (int s = 0; s < WORDS_PER_ENGINE; s++) begin
                        fq[e].push_back(mk_word(run_id, ep, r, e, s));
                        exp_q.push_back(mk_word(run_id, ep, r, e, s));
                    end
        end
        addr_model = v.addr;
        dimension  = v.dim;
        num_epochs = v.epochs;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        started = 1'b1;
    endtask

    task automatic finish_run(input vec_t v);
        int exp_words;
        exp_words = int'(v.exp_len / 64) * int'(v.epochs);
        for (int c = 0; c < 3000 && um_done !== 1'b1; c++) begin
            @(posedge clk);
            #1;
            bus.x_data_out_almost_full = v.af_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        bus.x_data_out_almost_full = 1'b0;
        check("um_done set", word_t'(um_done), word_t'(1));
        check("epoch_done count", word_t'(epochs_seen), word_t'(v.epochs));
        check("cmd count", word_t'(cmds_seen), word_t'((v.exp_len != 0) ? int'(v.epochs) : 0));
        check("word count", word_t'(words_seen), word_t'(exp_words));
        check("words left", word_t'(exp_q.size()), word_t'(0));
        started = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("um_done cleared", word_t'(um_done), word_t'(0));
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
        vecs[0] = '{32'd512,  32'd1, 64'h1000,  32'd2048, 1'b0};
        vecs[1] = '{32'd513,  32'd2, 64'h1000,  32'd4096, 1'b0};
        vecs[2] = '{32'd0,    32'd3, 64'h3000,  32'd0,    1'b0};
        vecs[3] = '{32'd100,  32'd0, 64'h4000,  32'd2048, 1'b0};
        vecs[4] = '{32'd1536, 32'd1, 64'h8000,  32'd6144, 1'b1};
        vecs[5] = '{32'd1024, 32'd2, 64'h10000, 32'd4096, 1'b1};

        n_checks = 0;
        n_fail = 0;
        run_id = 0;
        quiet = 1'b0;
        force_empty = '0;
        rst_n = 1'b0;
        started = 1'b0;
        addr_model = '0;
        dimension = '0;
        num_epochs = '0;
        bus.x_to_mem_rd_data = '0;
        bus.x_to_mem_empty = '1;
        bus.x_data_out_almost_full = 1'b0;
        fork
            fifo_loop();
            mon_loop();
        join_none

        @(negedge clk);
        check("reset start", word_t'(bus.x_data_send_back_start), word_t'(0));
        check("reset addr", word_t'(bus.x_data_send_back_addr), word_t'(0));
        check("reset length", word_t'(bus.x_data_send_back_length), word_t'(0));
        check("reset valid", word_t'(bus.x_data_out_valid), word_t'(0));
        check("reset data", bus.x_data_out, word_t'(0));
        check("reset rd_en", word_t'(bus.x_to_mem_rd_en), word_t'(0));
        check("reset epoch_done", word_t'(epoch_done), word_t'(0));
        check("reset um_done", word_t'(um_done), word_t'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            start_run(vecs[i]);
            finish_run(vecs[i]);
        end

        // almost_full held for 10 cycles mid-transfer.
        v = vecs[0];
        start_run(v);
        for (int c = 0; c < 500 && words_seen < 8; c++) begin
            @(posedge clk);
            #1;
        end
        bus.x_data_out_almost_full = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.x_data_out_almost_full = 1'b0;
        @(negedge clk);
        check("rd_en after af release", word_t'(bus.x_to_mem_rd_en != '0), word_t'(1));
        @(negedge clk);
        check("valid 1 cycle after release", word_t'(bus.x_data_out_valid), word_t'(1));
        finish_run(v);

        // FIFO 3 held empty: drain stops after engines 0..2.
        force_empty = '0;
        force_empty[3] = 1'b1;
        start_run(v);
        repeat (60) @(posedge clk);
        #1;
        check("words before empty fifo 3", word_t'(words_seen), word_t'(12));
        force_empty = '0;
        finish_run(v);

        // Abort after 5 words, then restart from scratch.
        start_run(v);
        for (int c = 0; c < 500 && words_seen < 5; c++) begin
            @(posedge clk);
            #1;
        end
        started = 1'b0;
        quiet = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        quiet = 1'b0;
        check("abort um_done", word_t'(um_done), word_t'(0));
        check("abort epoch_done", word_t'(epochs_seen), word_t'(0));
        check("abort cmd count", word_t'(cmds_seen), word_t'(1));
        start_run(v);
        finish_run(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sgd_x_fifo_drain_to_dma.md
Name: sgd_x_fifo_drain_to_dma

Overview:
- Downstream stage of the updated-model writer, in the DMA clock domain.
- Drains the ENGINE_NUM per-engine 512-bit CDC FIFOs that hold updated-model words.
- Re-serialises the words into host-memory order: row, then engine, then 4 words.
- Once per epoch, issues one DMA write command (start/addr/length), then streams the words with valid, honouring the host-side almost_full back-pressure.

Parameters:
- ENGINE_NUM, 8, number of engines, i.e. number of source FIFOs (power of two).
- WORDS_PER_ENGINE, 4, 512-bit words each engine contributes per row.
- BANK_FEATURES, 64, 32-bit features per engine per row.
- DATA_WIDTH, 512, FIFO and output word width.

Ports:
- clk  in  1  DMA clock.
- rst_n  in  1  asynchronous, active-low reset.
- started  in  1  run enable (level).
- addr_model  in  64  host byte address of the epoch-0 model image.
- dimension  in  32  number of features.
- numEpochs  in  32  number of epochs to write back.
- x_to_mem_rd_data  in  ENGINE_NUM x 512  FIFO read data; standard FIFO, valid 1 cycle after rd_en.
- x_to_mem_rd_en  out  ENGINE_NUM  one-hot FIFO pop.
- x_to_mem_empty  in  ENGINE_NUM  FIFO empty flags.
- x_data_send_back_start  out  1  1-cycle command pulse.
- x_data_send_back_addr  out  64  command byte address.
- x_data_send_back_length  out  32  command byte length.
- x_data_out  out  512  write data.
- x_data_out_valid  out  1  data qualifier.
- x_data_out_almost_full  in  1  host-path back-pressure; at least 3 cycles of slack.
- epoch_done  out  1  1-cycle pulse when an epoch's last word is emitted.
- um_done  out  1  sticky; all epochs written.

Behaviour:
- Reset and clock:
  - Asynchronous active-low reset; everything else is synchronous to clk.
  - Reset values: all outputs 0; internal state IDLE.
- State machine, one-hot IDLE, CALC, CMD, DATA, NEXT, DONE:
  - IDLE -> CALC on a rising edge of started (registered started low -> high).
  - CALC (1 cycle):
    - rows = (dimension + ENGINE_NUM*BANK_FEATURES - 1) >> log2(ENGINE_NUM*BANK_FEATURES).
    - words = rows * ENGINE_NUM * WORDS_PER_ENGINE.
    - length = words << 6 (bytes).
    - All 32-bit unsigned; overflow is not checked.
    - Clear epoch counter and base = addr_model.
  - CMD (1 cycle):
    - start=1, addr=base, length=length.
    - If length == 0: skip DATA and go to NEXT; no start pulse.
  - DATA:
    - Counters: sub (0..WORDS_PER_ENGINE-1), eng (0..ENGINE_NUM-1), wcnt (0..words-1).
    - pop = ~empty[eng] & ~almost_full; rd_en[eng] = pop.
    - On pop, sub increments; at its wrap, eng increments; at eng wrap, sub and eng both return to 0.
    - Cycle after a pop: x_data_out = rd_data[eng_d], valid=1 (eng_d = registered eng). Latency pop -> valid is exactly 1 cycle.
    - After the pop with wcnt == words-1 -> NEXT.
  - NEXT:
    - epoch_done=1 in the cycle the last word is valid (coincides with NEXT).
    - epoch+1; base += length.
    - If epoch+1 == numEpochs -> DONE, else -> CMD.
  - DONE: um_done=1; held until started goes low, then -> IDLE with um_done cleared.
- Boundaries:
  - numEpochs == 0: CALC -> DONE directly; no command.
  - dimension == 0: every epoch produces no command and no data; epoch_done still pulses once per epoch.
  - almost_full and empty both stall popping only. The state, counters and command are unaffected; no bubble is inserted after a stall.
  - started low in any state except IDLE/DONE: abort to IDLE next cycle; rd_en forced 0. A word popped the previous cycle is discarded (valid not raised).
  - Reset mid-transfer: immediate return to IDLE. FIFO contents are not flushed by this block.
  - Never pop an empty FIFO. Never pop more than words per epoch.

Optional Feature:
- Macro: SGD_X_DRAIN_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_full_cnt [31:0] and stall_empty_cnt [31:0].
  - Each increments per DATA-state cycle stalled by almost_full, or by empty[eng] with almost_full low.
  - Both clear on the IDLE -> CALC transition.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sgd_drain_pkg:
  - state enum (one-hot);
  - localparam ROW_FEATURES = ENGINE_NUM*BANK_FEATURES;
  - ROW_SHIFT = $clog2(ROW_FEATURES);
  - WORD_BYTES_SHIFT = 6.
- One natural sub-module, sgd_drain_len_calc: registered rows/words/length computation.

Test Plan (ENGINE_NUM=8):
- dimension=512, numEpochs=1, addr_model=0x1000, FIFOs prefilled → one start with addr=0x1000, length=2048; 32 valid words in order eng0 w0..w3, eng1 w0..w3 … eng7 w3; epoch_done with last word; um_done=1.
- dimension=513, numEpochs=2, addr_model=0x1000 → commands (0x1000, 4096) then (0x2000, 4096); 64 words each epoch; epoch_done pulses twice.
- almost_full held high for 10 cycles mid-DATA → rd_en=0 throughout those cycles; word sequence has no loss or duplication; valid resumes 1 cycle after release.
- FIFO 3 empty while eng=3 → rd_en stays 0 until empty[3] falls; no pops from FIFO 4 in between.
- dimension=0, numEpochs=3 → no start, no valid; 3 epoch_done pulses; um_done=1.
- started dropped after 5 words → no further rd_en or valid; state IDLE; restart yields a fresh command at addr_model.
